// File: rtl/vga_pixel_feeder_pkg.sv
// Shared types and default build constants for the VGA pixel feeder.
package vga_feeder_pkg;

    localparam int PIXEL_W         = 16;
    localparam int DEF_FRAME_WORDS = 1024 * 768;
    localparam int DEF_BURST_LEN   = 16;
    localparam int DEF_FIFO_DEPTH  = 64;
    localparam int DEF_ADDR_W      = 22;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE_WAIT,
        CHECK,
        REQ,
        RECV,
        DRAIN,
        DONE
    } feed_state_e;

endpackage

// File: rtl/vga_pixel_feeder_sync_fifo.sv
// Single-clock FIFO with registered read word, occupancy count and synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push on full is still taken
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            // read port sees pre-flush contents
            if (pop)
                dout <= do_pop ? mem[rd_ptr] : '0;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({do_push, do_pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end
        end
    end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Fetches one frame of RGB565 pixels in fixed bursts and serves vga_ctrl pixel requests.
module vga_pixel_feeder
    import vga_feeder_pkg::*;
#(
    parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int                BURST_LEN   = DEF_BURST_LEN,
    parameter int                FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_sync_i,
    input  logic                        data_req_i,
    output pixel_t                      dout_o,
    output logic                        rd_req_o,
    output logic [ADDR_W-1:0]           rd_addr_o,
    input  logic                        rd_ack_i,
    input  logic                        rd_valid_i,
    input  pixel_t                      rd_data_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        underflow_o
);

    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W  = $clog2(FRAME_WORDS + 1);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    feed_state_e       state;
    feed_state_e       state_n;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CNT_W-1:0]  fetched_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [LVL_W-1:0]  free_space;
    logic              fifo_empty;
    logic              last_beat;
    logic              in_burst;
    logic              push;

    assign free_space = LVL_W'(FIFO_DEPTH) - fifo_level_o;
    assign last_beat  = rd_valid_i && (beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign in_burst   = (state == RECV) || (state == DRAIN);
    // beats racing a frame_sync belong to the aborted frame
    assign push       = rd_valid_i && (state == RECV) && !frame_sync_i;
    assign rd_req_o   = (state == REQ);
    assign rd_addr_o  = fetch_addr;

    always_comb begin
        state_n = state;
        if (frame_sync_i) begin
            case (state)
                REQ:         state_n = rd_ack_i ? DRAIN : CHECK;
                RECV, DRAIN: state_n = last_beat ? CHECK : DRAIN;
                default:     state_n = CHECK;
            endcase
        end else begin
            case (state)
                CHECK: begin
                    if (fetched_cnt == CNT_W'(FRAME_WORDS))
                        state_n = DONE;
                    else if (free_space >= LVL_W'(BURST_LEN))
                        state_n = REQ;
                end
                REQ:         if (rd_ack_i)  state_n = RECV;
                RECV, DRAIN: if (last_beat) state_n = CHECK;
                default:     state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE_WAIT;
            fetch_addr  <= BASE_ADDR;
            fetched_cnt <= '0;
            beat_cnt    <= '0;
            underflow_o <= 1'b0;
        end else begin
            state <= state_n;
            if (frame_sync_i) begin
                fetch_addr  <= BASE_ADDR;
                fetched_cnt <= '0;
                underflow_o <= 1'b0;
            end else begin
                if (data_req_i && fifo_empty)
                    underflow_o <= 1'b1;
                if (state == RECV && last_beat) begin
                    fetch_addr  <= fetch_addr + ADDR_W'(BURST_LEN);
                    fetched_cnt <= fetched_cnt + CNT_W'(BURST_LEN);
                end
            end
            if (state == REQ && rd_ack_i)
                beat_cnt <= '0;
            else if (in_burst && rd_valid_i)
                beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

    sync_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (frame_sync_i),
        .push      (push),
        .push_data (rd_data_i),
        .pop       (data_req_i),
        .dout      (dout_o),
        .level     (fifo_level_o),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench: full-size-style feeder (1024-word frame) plus a 64-word frame build.
module tb_vga_pixel_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        fs = 1'b0, req = 1'b0, rd_ack = 1'b0, rd_valid = 1'b0;
    logic [15:0] rd_data = '0, dout;
    logic        rd_req, uf;
    logic [21:0] rd_addr;
    logic [6:0]  level;

    logic        fs_s = 1'b0, req_s = 1'b0, rd_ack_s = 1'b0, rd_valid_s = 1'b0;
    logic [15:0] rd_data_s = '0, dout_s;
    logic        rd_req_s, uf_s;
    logic [21:0] rd_addr_s;
    logic [6:0]  level_s;

    int          n_chk = 0, n_bad = 0;
    int          ack_delay = 2;
    int          beats_sent = 0;
    bit          streaming = 1'b0;
    logic [21:0] addr_log[$];
    int          bursts_s = 0;

    vga_pixel_feeder #(.FRAME_WORDS(1024), .BURST_LEN(16), .FIFO_DEPTH(64), .ADDR_W(22), .BASE_ADDR('0)) dut (
        .clk(clk), .rst(rst), .frame_sync_i(fs), .data_req_i(req), .dout_o(dout),
        .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_ack_i(rd_ack), .rd_valid_i(rd_valid),
        .rd_data_i(rd_data), .fifo_level_o(level), .underflow_o(uf)
    );

    vga_pixel_feeder #(.FRAME_WORDS(64), .BURST_LEN(16), .FIFO_DEPTH(64), .ADDR_W(22), .BASE_ADDR('0)) dut_s (
        .clk(clk), .rst(rst), .frame_sync_i(fs_s), .data_req_i(req_s), .dout_o(dout_s),
        .rd_req_o(rd_req_s), .rd_addr_o(rd_addr_s), .rd_ack_i(rd_ack_s), .rd_valid_i(rd_valid_s),
        .rd_data_i(rd_data_s), .fifo_level_o(level_s), .underflow_o(uf_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // one request cycle, one idle cycle; dout checked the cycle after the request
    task automatic pop_chk(input bit sm, input logic [15:0] exp, input string tag);
        @(negedge clk);
        if (sm) req_s = 1'b1; else req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        req_s = 1'b0;
        chk(tag, sm ? dout_s : dout, exp);
    endtask

    task automatic wait_ack(input int n0, input string tag);
        int k;
        for (k = 0; k < 300 && addr_log.size() <= n0; k++) @(negedge clk);
        if (addr_log.size() <= n0) chk(tag, 0, 1);
    endtask

    task automatic wait_beats(input int n, input string tag);
        int k;
        bit hit = 1'b0;
        for (k = 0; k < 400 && !hit; k++) begin
            @(posedge clk); #1;
            hit = streaming && (beats_sent == n);
        end
        if (!hit) chk(tag, 0, 1);
    endtask

    // main arbiter model: configurable ack latency, 16 beats of data = address
    initial begin
        int          dl;
        bit          ok;
        logic [21:0] a;
        forever begin
            @(negedge clk);
            if (rd_req && !rst) begin
                dl = ack_delay;
                ok = 1'b1;
                for (int d = 0; d < dl; d++) begin
                    @(negedge clk);
                    if (!rd_req) begin ok = 1'b0; break; end
                end
                if (ok) begin
                    a = rd_addr;
                    addr_log.push_back(a);
                    beats_sent = 0;
                    streaming = 1'b1;
                    rd_ack = 1'b1;
                    @(negedge clk);
                    rd_ack = 1'b0;
                    for (int i = 0; i < 16; i++) begin
                        rd_valid = 1'b1;
                        rd_data = 16'(a + 22'(i));
                        beats_sent = i + 1;
                        @(negedge clk);
                    end
                    rd_valid = 1'b0;
                    streaming = 1'b0;
                end
            end
        end
    end

    // small-build arbiter: immediate ack
    initial begin
        logic [21:0] a;
        forever begin
            @(negedge clk);
            if (rd_req_s) begin
                a = rd_addr_s;
                bursts_s++;
                rd_ack_s = 1'b1;
                @(negedge clk);
                rd_ack_s = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    rd_valid_s = 1'b1;
                    rd_data_s = 16'(a + 22'(i));
                    @(negedge clk);
                end
                rd_valid_s = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int cnt, n0, k;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_level", level, 0);
        chk("rst_uf", uf, 0);
        repeat (5) @(negedge clk);
        chk("idle_no_req", rd_req, 0);

        // initial fill: four bursts then stall at full
        fs = 1'b1; @(negedge clk); fs = 1'b0;
        for (k = 0; k < 500 && level != 64; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("fill_level", level, 64);
        chk("fill_req_stop", rd_req, 0);
        chk("fill_bursts", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("fill_addr", addr_log[i], 22'(16 * i));

        // ramp read of the whole frame
        for (int p = 0; p < 1024; p++) begin
            pop_chk(1'b0, 16'(p), "ramp_dout");
            if (p % 256 == 0) begin
                @(negedge clk);
                chk("ramp_hold", dout, 16'(p));
            end
        end
        chk("ramp_uf", uf, 0);
        chk("ramp_level", level, 0);
        chk("ramp_bursts", addr_log.size(), 64);
        cnt = 0;
        repeat (30) begin @(negedge clk); if (rd_req) cnt++; end
        chk("done_no_req", cnt, 0);

        // starvation: slow ack while pixels are requested
        ack_delay = 200;
        fs = 1'b1; @(negedge clk); fs = 1'b0;
        chk("fs_level", level, 0);
        for (int p = 0; p < 40; p++) pop_chk(1'b0, 16'h0000, "starve_dout");
        chk("starve_uf", uf, 1);
        ack_delay = 2;

        // abort a burst after 5 beats; frame_sync also clears underflow
        wait_beats(5, "wait_beat5");
        @(negedge clk);
        n0 = addr_log.size();
        fs = 1'b1; @(negedge clk); fs = 1'b0;
        chk("abort_uf_clr", uf, 0);
        chk("abort_level", level, 0);
        chk("abort_no_req", rd_req, 0);
        wait_ack(n0, "abort_reack");
        if (addr_log.size() > n0) chk("abort_addr", addr_log[n0], 0);
        for (k = 0; k < 100 && level < 3; k++) @(negedge clk);
        pop_chk(1'b0, 16'h0000, "abort_pix0");
        pop_chk(1'b0, 16'h0001, "abort_pix1");
        pop_chk(1'b0, 16'h0002, "abort_pix2");

        // reset in the middle of the second burst of a fresh frame
        @(negedge clk);
        n0 = addr_log.size();
        fs = 1'b1; @(negedge clk); fs = 1'b0;
        wait_ack(n0, "rst_ack1");
        wait_ack(n0 + 1, "rst_ack2");
        wait_beats(3, "wait_beat3");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_req", rd_req, 0);
        chk("mid_rst_addr", rd_addr, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_uf", uf, 0);
        rst = 1'b0;
        cnt = 0;
        repeat (40) begin @(negedge clk); if (rd_req) cnt++; end
        chk("post_rst_no_req", cnt, 0);
        chk("post_rst_level", level, 0);
        fs = 1'b1; @(negedge clk); fs = 1'b0;
        for (k = 0; k < 20 && !rd_req; k++) @(negedge clk);
        chk("post_rst_req", rd_req, 1);
        chk("post_rst_addr", rd_addr, 0);

        // small build: 64-word frame -> exactly 4 bursts, then DONE
        chk("s_idle", rd_req_s, 0);
        fs_s = 1'b1; @(negedge clk); fs_s = 1'b0;
        for (k = 0; k < 300 && level_s != 64; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("s_bursts", bursts_s, 4);
        for (int p = 0; p < 32; p++) pop_chk(1'b1, 16'(p), "s_dout");
        cnt = 0;
        repeat (40) begin @(negedge clk); if (rd_req_s) cnt++; end
        chk("s_done_no_req", cnt, 0);
        chk("s_bursts_after", bursts_s, 4);
        chk("s_level", level_s, 32);
        fs_s = 1'b1; @(negedge clk); fs_s = 1'b0;
        for (k = 0; k < 20 && !rd_req_s; k++) @(negedge clk);
        chk("s_rearm_req", rd_req_s, 1);
        chk("s_rearm_addr", rd_addr_s, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
